// File: rtl/umi_splitter_pkg.sv
// rtl/umi_splitter_pkg.sv - UMI splitter defaults, class-bit position and packet type
package umi_splitter_pkg;

  localparam int UMI_DEF_DW   = 256;
  localparam int UMI_DEF_AW   = 64;
  localparam int UMI_DEF_CW   = 32;

  // cmd bit that marks a packet as a response (1) or request (0)
  localparam int UMI_RESP_BIT = 0;

  typedef struct packed {
    logic [UMI_DEF_CW-1:0] cmd;
    logic [UMI_DEF_AW-1:0] dstaddr;
    logic [UMI_DEF_AW-1:0] srcaddr;
    logic [UMI_DEF_DW-1:0] data;
  } umi_pkt_t;

endpackage

// File: rtl/umi_skid_buf.sv
// rtl/umi_skid_buf.sv - 2-entry valid/ready skid buffer, one packet per cycle throughput
module umi_skid_buf import umi_splitter_pkg::*; #(
  parameter int PW = $bits(umi_pkt_t)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [PW-1:0] out_data,
  input  logic          out_ready
);

  logic [PW-1:0] mem_q [2];
  logic [PW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          push, pop;

  // Ready is held low while in reset so nothing is accepted into a buffer being cleared
  assign in_ready  = nreset & (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next-state: write at wr_ptr on push, advance rd_ptr on pop, count tracks occupancy
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  // Control state with synchronous reset; reset empties the buffer
  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Packet storage needs no reset: contents are only observed when cnt_q marks them valid
  always_ff @(posedge clk) begin
    mem_q[0] <= mem_d[0];
    mem_q[1] <= mem_d[1];
  end

endmodule

// File: rtl/umi_req_resp_splitter.sv
// rtl/umi_req_resp_splitter.sv - steers UMI packets to request/response outputs by cmd class; UMI_SPLITTER_PIPE_EN adds skid buffers
module umi_req_resp_splitter import umi_splitter_pkg::*; #(
  parameter int DW = UMI_DEF_DW,
  parameter int AW = UMI_DEF_AW,
  parameter int CW = UMI_DEF_CW
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          umi_in_valid,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic          umi_in_ready,
  output logic          umi_resp_out_valid,
  output logic [CW-1:0] umi_resp_out_cmd,
  output logic [AW-1:0] umi_resp_out_dstaddr,
  output logic [AW-1:0] umi_resp_out_srcaddr,
  output logic [DW-1:0] umi_resp_out_data,
  input  logic          umi_resp_out_ready,
  output logic          umi_req_out_valid,
  output logic [CW-1:0] umi_req_out_cmd,
  output logic [AW-1:0] umi_req_out_dstaddr,
  output logic [AW-1:0] umi_req_out_srcaddr,
  output logic [DW-1:0] umi_req_out_data,
  input  logic          umi_req_out_ready
);

  logic is_resp;
  assign is_resp = umi_in_cmd[UMI_RESP_BIT];

`ifdef UMI_SPLITTER_PIPE_EN

  localparam int PW = CW + 2*AW + DW;

  logic [PW-1:0] in_pkt;
  logic [PW-1:0] resp_pkt;
  logic [PW-1:0] req_pkt;
  logic          resp_in_ready;
  logic          req_in_ready;

  assign in_pkt = {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};

  // Each class has its own buffer, so a stalled consumer only blocks its own class
  umi_skid_buf #(.PW(PW)) u_resp_buf (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (umi_in_valid & is_resp),
    .in_data   (in_pkt),
    .in_ready  (resp_in_ready),
    .out_valid (umi_resp_out_valid),
    .out_data  (resp_pkt),
    .out_ready (umi_resp_out_ready)
  );

  umi_skid_buf #(.PW(PW)) u_req_buf (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (umi_in_valid & ~is_resp),
    .in_data   (in_pkt),
    .in_ready  (req_in_ready),
    .out_valid (umi_req_out_valid),
    .out_data  (req_pkt),
    .out_ready (umi_req_out_ready)
  );

  assign umi_in_ready = is_resp ? resp_in_ready : req_in_ready;

  assign {umi_resp_out_cmd, umi_resp_out_dstaddr, umi_resp_out_srcaddr, umi_resp_out_data} = resp_pkt;
  assign {umi_req_out_cmd,  umi_req_out_dstaddr,  umi_req_out_srcaddr,  umi_req_out_data}  = req_pkt;

`else

  // Zero-latency path: fields fan out to both outputs, only valid is steered
  assign umi_resp_out_valid   = umi_in_valid & is_resp;
  assign umi_req_out_valid    = umi_in_valid & ~is_resp;
  assign umi_in_ready         = is_resp ? umi_resp_out_ready : umi_req_out_ready;

  assign umi_resp_out_cmd     = umi_in_cmd;
  assign umi_resp_out_dstaddr = umi_in_dstaddr;
  assign umi_resp_out_srcaddr = umi_in_srcaddr;
  assign umi_resp_out_data    = umi_in_data;
  assign umi_req_out_cmd      = umi_in_cmd;
  assign umi_req_out_dstaddr  = umi_in_dstaddr;
  assign umi_req_out_srcaddr  = umi_in_srcaddr;
  assign umi_req_out_data     = umi_in_data;

  // clk and nreset are kept only so both builds share one port list
  logic unused_clk_nreset;
  assign unused_clk_nreset = clk ^ nreset;

`endif

endmodule

// File: tb/tb_umi_req_resp_splitter.sv
// tb/tb_umi_req_resp_splitter.sv - directed and randomised checks of umi_req_resp_splitter
module tb_umi_req_resp_splitter;

  localparam int DW = 256;
  localparam int AW = 64;
  localparam int CW = 32;
  localparam int PW = CW + 2*AW + DW;

  logic          clk;
  logic          nreset;
  logic          umi_in_valid;
  logic [CW-1:0] umi_in_cmd;
  logic [AW-1:0] umi_in_dstaddr;
  logic [AW-1:0] umi_in_srcaddr;
  logic [DW-1:0] umi_in_data;
  logic          umi_in_ready;
  logic          umi_resp_out_valid;
  logic [CW-1:0] umi_resp_out_cmd;
  logic [AW-1:0] umi_resp_out_dstaddr;
  logic [AW-1:0] umi_resp_out_srcaddr;
  logic [DW-1:0] umi_resp_out_data;
  logic          umi_resp_out_ready;
  logic          umi_req_out_valid;
  logic [CW-1:0] umi_req_out_cmd;
  logic [AW-1:0] umi_req_out_dstaddr;
  logic [AW-1:0] umi_req_out_srcaddr;
  logic [DW-1:0] umi_req_out_data;
  logic          umi_req_out_ready;

  int errors = 0;
  int checks = 0;
  int resp_xfers = 0;
  int req_xfers = 0;

  logic [PW-1:0] exp_resp[$];
  logic [PW-1:0] exp_req[$];
  logic [PW-1:0] got_resp[$];
  logic [PW-1:0] got_req[$];

  umi_req_resp_splitter #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk                  (clk),
    .nreset               (nreset),
    .umi_in_valid         (umi_in_valid),
    .umi_in_cmd           (umi_in_cmd),
    .umi_in_dstaddr       (umi_in_dstaddr),
    .umi_in_srcaddr       (umi_in_srcaddr),
    .umi_in_data          (umi_in_data),
    .umi_in_ready         (umi_in_ready),
    .umi_resp_out_valid   (umi_resp_out_valid),
    .umi_resp_out_cmd     (umi_resp_out_cmd),
    .umi_resp_out_dstaddr (umi_resp_out_dstaddr),
    .umi_resp_out_srcaddr (umi_resp_out_srcaddr),
    .umi_resp_out_data    (umi_resp_out_data),
    .umi_resp_out_ready   (umi_resp_out_ready),
    .umi_req_out_valid    (umi_req_out_valid),
    .umi_req_out_cmd      (umi_req_out_cmd),
    .umi_req_out_dstaddr  (umi_req_out_dstaddr),
    .umi_req_out_srcaddr  (umi_req_out_srcaddr),
    .umi_req_out_data     (umi_req_out_data),
    .umi_req_out_ready    (umi_req_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [AW-1:0] d,
                       input logic [AW-1:0] s, input logic [DW-1:0] x);
    umi_in_valid   = v;
    umi_in_cmd     = c;
    umi_in_dstaddr = d;
    umi_in_srcaddr = s;
    umi_in_data    = x;
  endtask

  // Transfer monitor: what the source handed over, split by the bench's own cmd[0] decode,
  // and what each consumer actually took
  always @(posedge clk) begin
    if (umi_in_valid && umi_in_ready) begin
      if (umi_in_cmd[0])
        exp_resp.push_back({umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data});
      else
        exp_req.push_back({umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data});
    end
    if (umi_resp_out_valid && umi_resp_out_ready) begin
      got_resp.push_back({umi_resp_out_cmd, umi_resp_out_dstaddr, umi_resp_out_srcaddr, umi_resp_out_data});
      resp_xfers++;
    end
    if (umi_req_out_valid && umi_req_out_ready) begin
      got_req.push_back({umi_req_out_cmd, umi_req_out_dstaddr, umi_req_out_srcaddr, umi_req_out_data});
      req_xfers++;
    end
  end

  initial begin
    int r0;
    int accepted;
    int budget;
    logic [DW-1:0] rdata;
    logic [CW-1:0] rcmd;
    logic acc;

    nreset             = 1'b0;
    umi_resp_out_ready = 1'b0;
    umi_req_out_ready  = 1'b0;
    drive(1'b0, 32'h1, '0, '0, '0);

`ifndef UMI_SPLITTER_PIPE_EN
    // Idle input: no valid on either side, even in reset
    @(negedge clk); #1;
    chk("idle_resp_valid", umi_resp_out_valid, 1'b0);
    chk("idle_req_valid",  umi_req_out_valid,  1'b0);
    // Reset has no effect on the combinational path
    umi_resp_out_ready = 1'b1;
    umi_req_out_ready  = 1'b1;
    drive(1'b1, 32'h1, 64'h10, 64'h0, 256'hAA);
    #1;
    chk("rst_passthru_valid", umi_resp_out_valid, 1'b1);
    chk("rst_passthru_ready", umi_in_ready,       1'b1);
    @(negedge clk);
    nreset = 1'b1;
    drive(1'b0, 32'h1, '0, '0, '0);

    // Response routing
    @(negedge clk);
    drive(1'b1, 32'h1, 64'h10, 64'h0, 256'hAA);
    umi_resp_out_ready = 1'b1;
    umi_req_out_ready  = 1'b1;
    #1;
    chk("t1_resp_valid", umi_resp_out_valid,   1'b1);
    chk("t1_resp_cmd",   umi_resp_out_cmd,     32'h1);
    chk("t1_resp_dst",   umi_resp_out_dstaddr, 64'h10);
    chk("t1_resp_data",  umi_resp_out_data,    256'hAA);
    chk("t1_req_valid",  umi_req_out_valid,    1'b0);
    chk("t1_req_cmd",    umi_req_out_cmd,      32'h1);
    chk("t1_in_ready",   umi_in_ready,         1'b1);

    // Request routing with the response side stalled
    @(negedge clk);
    drive(1'b1, 32'h2, 64'h20, 64'h5, 256'h55);
    umi_resp_out_ready = 1'b0;
    umi_req_out_ready  = 1'b1;
    #1;
    chk("t2_req_valid",  umi_req_out_valid,   1'b1);
    chk("t2_req_dst",    umi_req_out_dstaddr, 64'h20);
    chk("t2_req_src",    umi_req_out_srcaddr, 64'h5);
    chk("t2_resp_valid", umi_resp_out_valid,  1'b0);
    chk("t2_in_ready",   umi_in_ready,        1'b1);

    // Request back-pressure: held, then exactly one transfer
    @(negedge clk);
    drive(1'b1, 32'h4, 64'h30, 64'h6, 256'h77);
    umi_resp_out_ready = 1'b1;
    umi_req_out_ready  = 1'b0;
    #1;
    r0 = req_xfers;
    chk("t3_in_ready_low", umi_in_ready,      1'b0);
    chk("t3_req_valid",    umi_req_out_valid, 1'b1);
    @(negedge clk); #1;
    chk("t3_held_no_xfer", req_xfers, r0);
    umi_req_out_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, 32'h4, 64'h30, 64'h6, 256'h77);
    #1;
    chk("t3_one_xfer", req_xfers, r0 + 1);
    @(negedge clk); #1;
    chk("t3_no_dup", req_xfers, r0 + 1);

    // Response back-pressure ignores the request ready
    drive(1'b1, 32'h3, 64'h40, 64'h0, 256'h1);
    umi_resp_out_ready = 1'b0;
    umi_req_out_ready  = 1'b1;
    #1;
    chk("t4_in_ready_low", umi_in_ready, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, '0, '0, '0);
`else
    // Reset state of the buffered build
    drive(1'b1, 32'h1, '0, '0, '0);
    @(negedge clk); #1;
    chk("rst_in_ready",   umi_in_ready,       1'b0);
    chk("rst_resp_valid", umi_resp_out_valid, 1'b0);
    chk("rst_req_valid",  umi_req_out_valid,  1'b0);
    drive(1'b0, 32'h1, '0, '0, '0);
    @(negedge clk);
    nreset = 1'b1;
    #1;
    chk("post_rst_in_ready", umi_in_ready, 1'b1);

    // Four back-to-back responses: one per cycle after one cycle of latency
    umi_resp_out_ready = 1'b1;
    umi_req_out_ready  = 1'b1;
    drive(1'b1, 32'h1, 64'h10, 64'h0, 256'hB0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      chk("b2b_resp_valid", umi_resp_out_valid, 1'b1);
      chk("b2b_resp_data",  umi_resp_out_data,  256'hB0 + 256'(i - 1));
      chk("b2b_req_valid",  umi_req_out_valid,  1'b0);
      if (i < 4) drive(1'b1, 32'h1, 64'h10, 64'h0, 256'hB0 + 256'(i));
      else       drive(1'b0, 32'h1, 64'h10, 64'h0, 256'h0);
    end
    @(negedge clk); #1;
    chk("b2b_drained", umi_resp_out_valid, 1'b0);

    // Fill the response buffer; only the response class stalls
    umi_resp_out_ready = 1'b0;
    umi_req_out_ready  = 1'b0;
    drive(1'b1, 32'h1, 64'h0, 64'h0, 256'hC0);
    @(negedge clk);
    drive(1'b1, 32'h1, 64'h0, 64'h0, 256'hC1);
    @(negedge clk); #1;
    chk("full_resp_in_ready", umi_in_ready, 1'b0);
    drive(1'b1, 32'h2, 64'h0, 64'h0, 256'hD0);
    #1;
    chk("full_req_in_ready", umi_in_ready, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h2, '0, '0, '0);
    #1;
    chk("full_resp_head", umi_resp_out_data,  256'hC0);
    chk("full_req_valid", umi_req_out_valid,  1'b1);
    chk("full_req_data",  umi_req_out_data,   256'hD0);

    // Reset mid-stream discards buffered packets
    nreset = 1'b0;
    @(negedge clk); #1;
    chk("midrst_resp_valid", umi_resp_out_valid, 1'b0);
    chk("midrst_req_valid",  umi_req_out_valid,  1'b0);
    nreset             = 1'b1;
    umi_resp_out_ready = 1'b1;
    umi_req_out_ready  = 1'b1;
    @(negedge clk);
`endif

    // Random mixed traffic with random readies: each output must equal the input filtered by cmd[0]
    umi_resp_out_ready = 1'b1;
    umi_req_out_ready  = 1'b1;
    repeat (4) @(negedge clk);
    exp_resp.delete();
    exp_req.delete();
    got_resp.delete();
    got_req.delete();
    accepted = 0;
    budget   = 0;
    for (int n = 0; n < 100; n++) begin
      rcmd = $urandom;
      for (int k = 0; k < DW/32; k++) rdata[k*32 +: 32] = $urandom;
      drive(1'b1, rcmd, {$urandom, $urandom}, {$urandom, $urandom}, rdata);
      umi_resp_out_ready = ($urandom_range(3) != 0);
      umi_req_out_ready  = ($urandom_range(3) != 0);
      acc = 1'b0;
      while (!acc && budget < 4000) begin
        @(posedge clk);
        acc = umi_in_valid & umi_in_ready;
        @(negedge clk);
        budget++;
        umi_resp_out_ready = ($urandom_range(3) != 0);
        umi_req_out_ready  = ($urandom_range(3) != 0);
      end
      if (acc) accepted++;
    end
    drive(1'b0, 32'h0, '0, '0, '0);
    umi_resp_out_ready = 1'b1;
    umi_req_out_ready  = 1'b1;
    repeat (4) @(negedge clk);
    chk("rnd_accepted",    accepted, 100);
    chk("rnd_class_total", exp_resp.size() + exp_req.size(), 100);
    chk("rnd_resp_count",  got_resp.size(), exp_resp.size());
    chk("rnd_req_count",   got_req.size(),  exp_req.size());
    for (int i = 0; i < exp_resp.size() && i < got_resp.size(); i++)
      chk("rnd_resp_pkt", got_resp[i], exp_resp[i]);
    for (int i = 0; i < exp_req.size() && i < got_req.size(); i++)
      chk("rnd_req_pkt", got_req[i], exp_req[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
